// File: rtl/cmos_sync_decoder_if.sv
// Bundle for cmos_sync_decoder: deserializer lanes in, line-buffer stream and status out.
// The master drives the lanes, and the slave is the decoder.
interface cmos_sync_decoder_if;
  logic        relock;
  logic [11:0] ctrl_in;
  logic [11:0] data_in0;
  logic [11:0] data_in1;
  logic [11:0] data_in2;
  logic [11:0] data_in3;
  logic [11:0] data_in4;
  logic [11:0] data_in5;
  logic [11:0] data_in6;
  logic [11:0] data_in7;
  logic        fvals;
  logic        lvals;
  logic [11:0] datapar_out0;
  logic [11:0] datapar_out1;
  logic [11:0] datapar_out2;
  logic [11:0] datapar_out3;
  logic [11:0] datapar_out4;
  logic [11:0] datapar_out5;
  logic [11:0] datapar_out6;
  logic [11:0] datapar_out7;
  logic        locked;
  logic [11:0] line_cnt;
  logic        len_err;
  logic        proto_err;

  modport master (
    output relock, ctrl_in,
    output data_in0, data_in1, data_in2, data_in3,
    output data_in4, data_in5, data_in6, data_in7,
    input  fvals, lvals, locked, line_cnt, len_err, proto_err,
    input  datapar_out0, datapar_out1, datapar_out2, datapar_out3,
    input  datapar_out4, datapar_out5, datapar_out6, datapar_out7
  );

  modport slave (
    input  relock, ctrl_in,
    input  data_in0, data_in1, data_in2, data_in3,
    input  data_in4, data_in5, data_in6, data_in7,
    output fvals, lvals, locked, line_cnt, len_err, proto_err,
    output datapar_out0, datapar_out1, datapar_out2, datapar_out3,
    output datapar_out4, datapar_out5, datapar_out6, datapar_out7
  );
endinterface

// File: rtl/cmos_sync_decoder.sv
// Locks to the sensor training word and decodes control-lane sync codes into
// fvals/lvals and a zero-masked eight-lane pixel stream with lock and error status.
module cmos_sync_decoder #(
  parameter logic [11:0] CODE_TRAIN = 12'h055,
  parameter logic [11:0] CODE_SOF   = 12'hA01,
  parameter logic [11:0] CODE_SOL   = 12'hA02,
  parameter logic [11:0] CODE_EOL   = 12'hA04,
  parameter logic [11:0] CODE_EOF   = 12'hA08,
  parameter int          LOCK_CNT   = 16,
  parameter int          LINE_LEN   = 128
) (
  input logic                clk_rxg,
  input logic                rst_rx_n,
  cmos_sync_decoder_if.slave bus
);
  localparam int TRAIN_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {s_UNLOCK, s_IDLE, s_GAP, s_LINE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [11:0]          w_dataIn   [8];
  logic [11:0]          r_dataD1   [8];
  logic [11:0]          r_ctrlD1;
  logic [11:0]          r_dataOut  [8];
  logic [11:0]          w_dataNext [8];
  logic                 r_fvals, r_lvals, r_locked, r_lenErr, r_protoErr;
  logic                 w_fvalsNext, w_lvalsNext, w_lockedNext, w_lenErrNext, w_protoErrNext;
  logic [TRAIN_W-1:0]   r_trainCnt, w_trainCntNext;
  logic [11:0]          r_pixCnt, w_pixCntNext;
  logic [11:0]          r_lineCnt, w_lineCntNext;
  logic                 w_isTrain, w_isSof, w_isSol, w_isEol, w_isEof, w_isCode;
  logic                 w_timeout;

  assign w_dataIn[0] = bus.data_in0;
  assign w_dataIn[1] = bus.data_in1;
  assign w_dataIn[2] = bus.data_in2;
  assign w_dataIn[3] = bus.data_in3;
  assign w_dataIn[4] = bus.data_in4;
  assign w_dataIn[5] = bus.data_in5;
  assign w_dataIn[6] = bus.data_in6;
  assign w_dataIn[7] = bus.data_in7;

  assign w_isTrain = (r_ctrlD1 == CODE_TRAIN);
  assign w_isSof   = (r_ctrlD1 == CODE_SOF);
  assign w_isSol   = (r_ctrlD1 == CODE_SOL);
  assign w_isEol   = (r_ctrlD1 == CODE_EOL);
  assign w_isEof   = (r_ctrlD1 == CODE_EOF);
  assign w_isCode  = w_isTrain | w_isSof | w_isSol | w_isEol | w_isEof;
  // A pixel that would bring pix_cnt to 4095 without an end code ends the line.
  assign w_timeout = !w_isCode && (r_pixCnt == 12'hFFE);

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      r_ctrlD1 <= '0;
      for (int n = 0; n < 8; n++) r_dataD1[n] <= '0;
    end else begin
      r_ctrlD1 <= bus.ctrl_in;
      for (int n = 0; n < 8; n++) r_dataD1[n] <= w_dataIn[n];
    end
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) r_state <= s_UNLOCK;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (bus.relock) begin
      w_nextState = s_UNLOCK;
    end else begin
      unique case (r_state)
        s_UNLOCK: if (w_isTrain && r_trainCnt == TRAIN_W'(LOCK_CNT - 1)) w_nextState = s_IDLE;
        s_IDLE:   if (w_isSof) w_nextState = s_LINE;
        s_LINE: begin
          if (w_isEol)        w_nextState = s_GAP;
          else if (w_isEof)   w_nextState = s_IDLE;
          else if (w_timeout) w_nextState = s_GAP;
        end
        s_GAP: begin
          if (w_isSol)      w_nextState = s_LINE;
          else if (w_isEof) w_nextState = s_IDLE;
        end
        default: w_nextState = s_UNLOCK;
      endcase
    end
  end

  // fvals and locked follow the state being entered, so they move on the decode edge.
  always_comb begin
    w_fvalsNext    = (w_nextState == s_LINE) || (w_nextState == s_GAP);
    w_lockedNext   = (w_nextState != s_UNLOCK);
    w_lvalsNext    = 1'b0;
    for (int n = 0; n < 8; n++) w_dataNext[n] = '0;
    w_trainCntNext = r_trainCnt;
    w_pixCntNext   = r_pixCnt;
    w_lineCntNext  = r_lineCnt;
    w_lenErrNext   = r_lenErr;
    w_protoErrNext = r_protoErr;
    if (bus.relock) begin
      w_trainCntNext = '0;
      w_pixCntNext   = '0;
    end else begin
      unique case (r_state)
        s_UNLOCK: begin
          w_trainCntNext = (w_isTrain && w_nextState == s_UNLOCK) ?
                           r_trainCnt + TRAIN_W'(1) : '0;
        end
        s_IDLE: begin
          if (w_isSof) begin
            w_pixCntNext   = '0;
            w_lineCntNext  = '0;
            w_lenErrNext   = 1'b0;
            w_protoErrNext = 1'b0;
          end
        end
        s_LINE: begin
          if (!w_isCode) begin
            w_lvalsNext  = 1'b1;
            for (int n = 0; n < 8; n++) w_dataNext[n] = r_dataD1[n];
            w_pixCntNext = r_pixCnt + 12'd1;
            if (w_timeout) w_protoErrNext = 1'b1;
          end else if (w_isEol || w_isEof) begin
            if (r_lineCnt != 12'hFFF) w_lineCntNext = r_lineCnt + 12'd1;
            if (r_pixCnt != 12'(LINE_LEN)) w_lenErrNext = 1'b1;
          end else if (w_isSof || w_isSol) begin
            w_protoErrNext = 1'b1;
          end
        end
        s_GAP: begin
          if (w_isSol)                 w_pixCntNext   = '0;
          else if (w_isSof || w_isEol) w_protoErrNext = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      r_fvals    <= 1'b0;
      r_lvals    <= 1'b0;
      r_locked   <= 1'b0;
      r_trainCnt <= '0;
      r_pixCnt   <= '0;
      r_lineCnt  <= '0;
      r_lenErr   <= 1'b0;
      r_protoErr <= 1'b0;
      for (int n = 0; n < 8; n++) r_dataOut[n] <= '0;
    end else begin
      r_fvals    <= w_fvalsNext;
      r_lvals    <= w_lvalsNext;
      r_locked   <= w_lockedNext;
      r_trainCnt <= w_trainCntNext;
      r_pixCnt   <= w_pixCntNext;
      r_lineCnt  <= w_lineCntNext;
      r_lenErr   <= w_lenErrNext;
      r_protoErr <= w_protoErrNext;
      for (int n = 0; n < 8; n++) r_dataOut[n] <= w_dataNext[n];
    end
  end

  assign bus.fvals        = r_fvals;
  assign bus.lvals        = r_lvals;
  assign bus.locked       = r_locked;
  assign bus.line_cnt     = r_lineCnt;
  assign bus.len_err      = r_lenErr;
  assign bus.proto_err    = r_protoErr;
  assign bus.datapar_out0 = r_dataOut[0];
  assign bus.datapar_out1 = r_dataOut[1];
  assign bus.datapar_out2 = r_dataOut[2];
  assign bus.datapar_out3 = r_dataOut[3];
  assign bus.datapar_out4 = r_dataOut[4];
  assign bus.datapar_out5 = r_dataOut[5];
  assign bus.datapar_out6 = r_dataOut[6];
  assign bus.datapar_out7 = r_dataOut[7];
endmodule
